// File: rtl/data_table_upsert_pkg.sv
// ---- data_table_upsert_pkg : shared hash table types for the data RAM writer (rev 1.0)
`default_nettype none

package data_table_upsert_pkg;

    localparam int KEY_WIDTH             = 16;
    localparam int VALUE_WIDTH           = 16;
    localparam int BUCKET_WIDTH          = 8;
    localparam int TABLE_ADDR_WIDTH      = 8;
    localparam int MAX_CHAIN_LEN_DEFAULT = 8;

    typedef enum logic [2:0] {
        OP_SEARCH     = 3'd0,
        OP_INSERT     = 3'd1,
        OP_DELETE     = 3'd2,
        OP_INSERT_NEW = 3'd3,
        OP_UPDATE     = 3'd4
    } ht_cmd_t;

    typedef enum logic [3:0] {
        SEARCH_FOUND                     = 4'd0,
        SEARCH_NOT_SUCCESS_NO_ENTRY      = 4'd1,
        INSERT_SUCCESS                   = 4'd2,
        INSERT_SUCCESS_SAME_KEY          = 4'd3,
        INSERT_NOT_SUCCESS_TABLE_IS_FULL = 4'd4,
        DELETE_SUCCESS                   = 4'd5,
        DELETE_NOT_SUCCESS_NO_ENTRY      = 4'd6,
        INSERT_NOT_SUCCESS_KEY_EXISTS    = 4'd7,
        INSERT_NOT_SUCCESS_CHAIN_LIMIT   = 4'd8,
        UPDATE_SUCCESS                   = 4'd9,
        UPDATE_NOT_SUCCESS_NO_KEY        = 4'd10
    } ht_rslt_t;

    typedef struct packed {
        logic [KEY_WIDTH-1:0]        key;
        logic [VALUE_WIDTH-1:0]      value;
        logic [TABLE_ADDR_WIDTH-1:0] next_ptr;
        logic                        next_ptr_val;
    } ram_data_t;

    typedef struct packed {
        logic [KEY_WIDTH-1:0]        key;
        logic [VALUE_WIDTH-1:0]      value;
        logic [BUCKET_WIDTH-1:0]     bucket;
        logic [TABLE_ADDR_WIDTH-1:0] head_ptr;
        logic                        head_ptr_val;
        ht_cmd_t                     cmd;
    } ht_data_task_t;

    typedef struct packed {
        ht_cmd_t                cmd;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
        ht_rslt_t               rslt;
    } ht_result_t;

    typedef enum logic [2:0] {
        IDLE_S            = 3'd0,
        WALK_RD_S         = 3'd1,
        WALK_WAIT_S       = 3'd2,
        UPD_VALUE_S       = 3'd3,
        ALLOC_HEAD_S      = 3'd4,
        ALLOC_TAIL_DATA_S = 3'd5,
        ALLOC_TAIL_LINK_S = 3'd6,
        RESULT_S          = 3'd7
    } upsert_state_t;

endpackage

`default_nettype wire

// File: rtl/head_table_if.sv
// ---- head_table_if : head table write port (rev 1.0)
`default_nettype none

interface head_table_if
    import data_table_upsert_pkg::*;
#(
    parameter int A_WIDTH = TABLE_ADDR_WIDTH
);
    logic [BUCKET_WIDTH-1:0] wr_addr;
    logic [A_WIDTH-1:0]      wr_ptr;
    logic                    wr_ptr_val;
    logic                    wr_en;

    modport master (output wr_addr, wr_ptr, wr_ptr_val, wr_en);
    modport slave  (input  wr_addr, wr_ptr, wr_ptr_val, wr_en);
endinterface

`default_nettype wire

// File: rtl/data_table_upsert_rd_valid_delay.sv
// ---- rd_valid_delay : read-enable delay line that marks when data RAM read data is valid (rev 1.0)
`default_nettype none

module rd_valid_delay #(
    parameter int DEPTH = 2
)(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic rd_en_i,
    output logic rd_data_val_o
);
    logic [DEPTH-1:0] pipe;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) pipe <= '0;
        else          pipe <= (pipe << 1) | DEPTH'(rd_en_i);
    end

    assign rd_data_val_o = pipe[DEPTH-1];
endmodule

`default_nettype wire

// File: rtl/data_table_upsert.sv
// ---- data_table_upsert : chain-walking insert / insert-new / update writer for the hash table data RAM (rev 1.0)
`default_nettype none

module data_table_upsert
    import data_table_upsert_pkg::*;
#(
    parameter int RAM_LATENCY   = 2,
    parameter int A_WIDTH       = TABLE_ADDR_WIDTH,
    parameter int MAX_CHAIN_LEN = MAX_CHAIN_LEN_DEFAULT,
    parameter int HOP_W         = $clog2(MAX_CHAIN_LEN + 1)
)(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  ht_data_task_t      task_i,
    input  logic               task_valid_i,
    output logic               task_ready_o,
    input  ram_data_t          rd_data_i,
    output logic [A_WIDTH-1:0] rd_addr_o,
    output logic               rd_en_o,
    output logic [A_WIDTH-1:0] wr_addr_o,
    output ram_data_t          wr_data_o,
    output logic               wr_en_o,
    input  logic [A_WIDTH-1:0] empty_addr_i,
    input  logic               empty_addr_val_i,
    output logic               empty_addr_rd_ack_o,
    head_table_if.master       head_table,
    output ht_result_t         result_o,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [HOP_W-1:0]   result_hops_o
);
    upsert_state_t          state;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [VALUE_WIDTH-1:0] value_q;
    ht_cmd_t                cmd_q;
    ht_rslt_t               code_q;
    ram_data_t              node_q;
    logic [A_WIDTH-1:0]     cur_addr;
    logic [A_WIDTH-1:0]     alloc_addr;
    logic [HOP_W-1:0]       hops;
    logic                   rd_data_val;
    logic                   key_hit;
    logic                   at_limit;

    rd_valid_delay #(.DEPTH(RAM_LATENCY)) u_rd_valid_delay (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .rd_en_i       (rd_en_o),
        .rd_data_val_o (rd_data_val)
    );

    assign key_hit       = (rd_data_i.key == key_q);
    assign at_limit      = (hops == HOP_W'(MAX_CHAIN_LEN));
    assign result_o      = '{cmd: cmd_q, key: key_q, value: value_q, rslt: code_q};
    assign result_hops_o = hops;

    // All strobes are registered: each is set on the edge that enters the state which owns it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state                 <= IDLE_S;
            task_ready_o          <= 1'b1;
            key_q                 <= '0;
            value_q               <= '0;
            cmd_q                 <= OP_SEARCH;
            code_q                <= SEARCH_FOUND;
            node_q                <= '0;
            cur_addr              <= '0;
            alloc_addr            <= '0;
            hops                  <= '0;
            rd_en_o               <= 1'b0;
            rd_addr_o             <= '0;
            wr_en_o               <= 1'b0;
            wr_addr_o             <= '0;
            wr_data_o             <= '0;
            empty_addr_rd_ack_o   <= 1'b0;
            head_table.wr_en      <= 1'b0;
            head_table.wr_addr    <= '0;
            head_table.wr_ptr     <= '0;
            head_table.wr_ptr_val <= 1'b0;
            result_valid_o        <= 1'b0;
        end else begin
            rd_en_o             <= 1'b0;
            wr_en_o             <= 1'b0;
            empty_addr_rd_ack_o <= 1'b0;
            head_table.wr_en    <= 1'b0;
            case (state)
                IDLE_S: if (task_valid_i) begin
                    key_q        <= task_i.key;
                    value_q      <= task_i.value;
                    cmd_q        <= task_i.cmd;
                    task_ready_o <= 1'b0;
                    hops         <= '0;
                    if (task_i.head_ptr_val) begin
                        cur_addr  <= A_WIDTH'(task_i.head_ptr);
                        rd_addr_o <= A_WIDTH'(task_i.head_ptr);
                        rd_en_o   <= 1'b1;
                        hops      <= HOP_W'(1);
                        state     <= WALK_RD_S;
                    end else if (task_i.cmd == OP_UPDATE || !empty_addr_val_i) begin
                        code_q         <= (task_i.cmd == OP_UPDATE) ? UPDATE_NOT_SUCCESS_NO_KEY
                                                                    : INSERT_NOT_SUCCESS_TABLE_IS_FULL;
                        result_valid_o <= 1'b1;
                        state          <= RESULT_S;
                    end else begin
                        alloc_addr            <= empty_addr_i;
                        empty_addr_rd_ack_o   <= 1'b1;
                        head_table.wr_en      <= 1'b1;
                        head_table.wr_addr    <= task_i.bucket;
                        head_table.wr_ptr     <= empty_addr_i;
                        head_table.wr_ptr_val <= 1'b1;
                        wr_en_o               <= 1'b1;
                        wr_addr_o             <= empty_addr_i;
                        wr_data_o             <= '{key: task_i.key, value: task_i.value,
                                                   next_ptr: '0, next_ptr_val: 1'b0};
                        state                 <= ALLOC_HEAD_S;
                    end
                end
                WALK_RD_S: state <= WALK_WAIT_S;
                WALK_WAIT_S: if (rd_data_val) begin
                    node_q <= rd_data_i;
                    if (key_hit && (cmd_q == OP_INSERT || cmd_q == OP_UPDATE)) begin
                        code_q    <= (cmd_q == OP_INSERT) ? INSERT_SUCCESS_SAME_KEY : UPDATE_SUCCESS;
                        wr_en_o   <= 1'b1;
                        wr_addr_o <= cur_addr;
                        wr_data_o <= '{key: rd_data_i.key, value: value_q,
                                       next_ptr: rd_data_i.next_ptr,
                                       next_ptr_val: rd_data_i.next_ptr_val};
                        state     <= UPD_VALUE_S;
                    end else if (key_hit) begin
                        code_q         <= INSERT_NOT_SUCCESS_KEY_EXISTS;
                        result_valid_o <= 1'b1;
                        state          <= RESULT_S;
                    end else if (!rd_data_i.next_ptr_val) begin
                        if (cmd_q == OP_UPDATE || at_limit || !empty_addr_val_i) begin
                            code_q         <= (cmd_q == OP_UPDATE) ? UPDATE_NOT_SUCCESS_NO_KEY :
                                              at_limit             ? INSERT_NOT_SUCCESS_CHAIN_LIMIT :
                                                                     INSERT_NOT_SUCCESS_TABLE_IS_FULL;
                            result_valid_o <= 1'b1;
                            state          <= RESULT_S;
                        end else begin
                            alloc_addr          <= empty_addr_i;
                            empty_addr_rd_ack_o <= 1'b1;
                            wr_en_o             <= 1'b1;
                            wr_addr_o           <= empty_addr_i;
                            wr_data_o           <= '{key: key_q, value: value_q,
                                                     next_ptr: '0, next_ptr_val: 1'b0};
                            state               <= ALLOC_TAIL_DATA_S;
                        end
                    end else if (at_limit) begin
                        // A chain longer than the limit means a corrupted link; refuse without writing.
                        code_q         <= INSERT_NOT_SUCCESS_CHAIN_LIMIT;
                        result_valid_o <= 1'b1;
                        state          <= RESULT_S;
                    end else begin
                        cur_addr  <= A_WIDTH'(rd_data_i.next_ptr);
                        rd_addr_o <= A_WIDTH'(rd_data_i.next_ptr);
                        rd_en_o   <= 1'b1;
                        hops      <= hops + HOP_W'(1);
                        state     <= WALK_RD_S;
                    end
                end
                UPD_VALUE_S, ALLOC_HEAD_S, ALLOC_TAIL_LINK_S: begin
                    if (state != UPD_VALUE_S) code_q <= INSERT_SUCCESS;
                    result_valid_o <= 1'b1;
                    state          <= RESULT_S;
                end
                ALLOC_TAIL_DATA_S: begin
                    wr_en_o   <= 1'b1;
                    wr_addr_o <= cur_addr;
                    wr_data_o <= '{key: node_q.key, value: node_q.value,
                                   next_ptr: TABLE_ADDR_WIDTH'(alloc_addr), next_ptr_val: 1'b1};
                    state     <= ALLOC_TAIL_LINK_S;
                end
                RESULT_S: if (result_ready_i) begin
                    result_valid_o <= 1'b0;
                    task_ready_o   <= 1'b1;
                    state          <= IDLE_S;
                end
                default: state <= IDLE_S;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_data_table_upsert.sv
// ---- tb_data_table_upsert : directed self-checking bench for data_table_upsert (rev 1.0)
`default_nettype none

module tb_data_table_upsert;
    import data_table_upsert_pkg::*;

    localparam int L = 2;

    logic          clk = 1'b0;
    logic          rst_n_i = 1'b0;
    ht_data_task_t task_i = '0;
    logic          task_valid_i = 1'b0;
    logic          task_ready_o;
    ram_data_t     rd_data_i;
    logic [7:0]    rd_addr_o, wr_addr_o;
    logic          rd_en_o, wr_en_o;
    ram_data_t     wr_data_o;
    logic [7:0]    empty_addr_i = '0;
    logic          empty_addr_val_i = 1'b0;
    logic          empty_addr_rd_ack_o;
    ht_result_t    result_o;
    logic          result_valid_o;
    logic          result_ready_i = 1'b1;
    logic [1:0]    result_hops_o;

    head_table_if #(.A_WIDTH(8)) ht ();

    data_table_upsert #(.RAM_LATENCY(L), .A_WIDTH(8), .MAX_CHAIN_LEN(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .task_i(task_i), .task_valid_i(task_valid_i),
        .task_ready_o(task_ready_o), .rd_data_i(rd_data_i), .rd_addr_o(rd_addr_o),
        .rd_en_o(rd_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_en_o(wr_en_o),
        .empty_addr_i(empty_addr_i), .empty_addr_val_i(empty_addr_val_i),
        .empty_addr_rd_ack_o(empty_addr_rd_ack_o), .head_table(ht), .result_o(result_o),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_hops_o(result_hops_o)
    );

    always #5 clk = ~clk;

    // Data RAM model with L-cycle read latency plus a preload port.
    ram_data_t  mem [256];
    ram_data_t  rd_pipe [L];
    logic       pre_en = 1'b0;
    logic [7:0] pre_addr = '0;
    ram_data_t  pre_data = '0;
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (pre_en)  mem[pre_addr]  <= pre_data;
        if (wr_en_o) mem[wr_addr_o] <= wr_data_o;
        rd_pipe[0] <= mem[rd_addr_o];
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign rd_data_i = rd_pipe[L-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Activity monitor, sampled mid-cycle.
    int         acc_q[$], res_q[$], wc_q[$];
    ht_rslt_t   rc_q[$];
    int         rh_q[$];
    logic [7:0] rd_q[$], wa_q[$];
    ram_data_t  wd_q[$];
    int         ack_n, hw_n, hw_cyc;
    logic [7:0] hw_addr, hw_ptr;
    logic       hw_val, rv_prev = 1'b0;
    always @(negedge clk) begin
        if (task_valid_i && task_ready_o) acc_q.push_back(cyc);
        if (result_valid_o && !rv_prev) begin
            res_q.push_back(cyc); rc_q.push_back(result_o.rslt); rh_q.push_back(int'(result_hops_o));
        end
        rv_prev = result_valid_o;
        if (rd_en_o) rd_q.push_back(rd_addr_o);
        if (wr_en_o) begin wa_q.push_back(wr_addr_o); wd_q.push_back(wr_data_o); wc_q.push_back(cyc); end
        if (empty_addr_rd_ack_o) ack_n++;
        if (ht.wr_en) begin hw_n++; hw_addr = ht.wr_addr; hw_ptr = ht.wr_ptr; hw_val = ht.wr_ptr_val; hw_cyc = cyc; end
    end

    int vectors = 0, errors = 0;
    logic timed_out;

    function automatic ram_data_t mk(input logic [15:0] k, input logic [15:0] v, input logic [7:0] np, input logic npv);
        mk = '{key: k, value: v, next_ptr: np, next_ptr_val: npv};
    endfunction

    task automatic clear_logs();
        acc_q.delete(); res_q.delete(); rc_q.delete(); rh_q.delete(); rd_q.delete();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); ack_n = 0; hw_n = 0; hw_cyc = -1;
    endtask

    task automatic poke(input logic [7:0] a, input ram_data_t d);
        pre_addr = a; pre_data = d; pre_en = 1'b1;
        @(posedge clk); #1; pre_en = 1'b0;
    endtask

    task automatic run_task(input logic [15:0] k, input logic [15:0] v, input logic [7:0] b,
                            input logic [7:0] hp, input logic hpv, input ht_cmd_t c);
        int n;
        clear_logs();
        task_i = '{key: k, value: v, bucket: b, head_ptr: hp, head_ptr_val: hpv, cmd: c};
        task_valid_i = 1'b1;
        n = 0;
        while (acc_q.size() == 0 && n < 50) begin @(posedge clk); #1; n++; end
        task_valid_i = 1'b0;
        n = 0;
        while (res_q.size() == 0 && n < 100) begin @(posedge clk); #1; n++; end
        timed_out = (res_q.size() == 0 || acc_q.size() == 0);
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (task_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", task_ready_o); end
        vectors++; if ({rd_en_o, wr_en_o, empty_addr_rd_ack_o, ht.wr_en, result_valid_o} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes: got %b want 00000", {rd_en_o, wr_en_o, empty_addr_rd_ack_o, ht.wr_en, result_valid_o}); end
        vectors++; if ({rd_addr_o, wr_addr_o, wr_data_o, result_hops_o} !== '0) begin
            errors++; $display("FAIL reset_data: got %h/%h/%h/%h want 0", rd_addr_o, wr_addr_o, wr_data_o, result_hops_o); end
        rst_n_i = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_head_insert();
        empty_addr_i = 8'h05; empty_addr_val_i = 1'b1;
        run_task(16'h0011, 16'h0055, 8'h03, 8'h00, 1'b0, OP_INSERT);
        vectors++; if (timed_out) begin errors++; $display("FAIL head_timeout: got none want result"); end
        vectors++; if (rc_q[0] !== INSERT_SUCCESS) begin errors++; $display("FAIL head_code: got %0d want %0d", rc_q[0], INSERT_SUCCESS); end
        vectors++; if (rh_q[0] !== 0) begin errors++; $display("FAIL head_hops: got %0d want 0", rh_q[0]); end
        vectors++; if (res_q[0] - acc_q[0] !== 2) begin errors++; $display("FAIL head_latency: got %0d want 2", res_q[0] - acc_q[0]); end
        vectors++; if ({hw_n, hw_addr, hw_ptr, hw_val} !== {32'd1, 8'h03, 8'h05, 1'b1}) begin
            errors++; $display("FAIL head_tbl_wr: got n=%0d a=%h p=%h v=%b want n=1 a=03 p=05 v=1", hw_n, hw_addr, hw_ptr, hw_val); end
        vectors++; if (wa_q.size() !== 1 || wa_q[0] !== 8'h05 || wd_q[0] !== mk(16'h11, 16'h55, 8'h00, 1'b0)) begin
            errors++; $display("FAIL head_data_wr: got n=%0d a=%h d=%h want n=1 a=05 d=%h", wa_q.size(), wa_q[0], wd_q[0], mk(16'h11, 16'h55, 8'h00, 1'b0)); end
        vectors++; if (wc_q[0] !== hw_cyc) begin errors++; $display("FAIL head_same_cycle: got %0d want %0d", wc_q[0], hw_cyc); end
        vectors++; if (ack_n !== 1) begin errors++; $display("FAIL head_ack: got %0d want 1", ack_n); end
    endtask

    task automatic test_same_key();
        poke(8'h05, mk(16'h11, 16'h55, 8'h09, 1'b1));
        poke(8'h09, mk(16'h22, 16'h66, 8'h00, 1'b0));
        empty_addr_i = 8'h0E; empty_addr_val_i = 1'b1;
        run_task(16'h0022, 16'h00AB, 8'h03, 8'h05, 1'b1, OP_INSERT);
        vectors++; if (timed_out || rc_q[0] !== INSERT_SUCCESS_SAME_KEY) begin errors++; $display("FAIL same_code: got %0d want %0d", rc_q[0], INSERT_SUCCESS_SAME_KEY); end
        vectors++; if (rh_q[0] !== 2) begin errors++; $display("FAIL same_hops: got %0d want 2", rh_q[0]); end
        vectors++; if (rd_q.size() !== 2 || rd_q[0] !== 8'h05 || rd_q[1] !== 8'h09) begin
            errors++; $display("FAIL same_reads: got n=%0d %h,%h want n=2 05,09", rd_q.size(), rd_q[0], rd_q[1]); end
        vectors++; if (wa_q.size() !== 1 || wa_q[0] !== 8'h09 || wd_q[0] !== mk(16'h22, 16'hAB, 8'h00, 1'b0)) begin
            errors++; $display("FAIL same_write: got n=%0d a=%h d=%h want n=1 a=09", wa_q.size(), wa_q[0], wd_q[0]); end
        vectors++; if (res_q[0] - acc_q[0] !== 8) begin errors++; $display("FAIL same_latency: got %0d want 8", res_q[0] - acc_q[0]); end
        vectors++; if (ack_n !== 0 || hw_n !== 0) begin errors++; $display("FAIL same_no_alloc: got ack=%0d hw=%0d want 0/0", ack_n, hw_n); end
    endtask

    task automatic test_insert_new_update();
        run_task(16'h0011, 16'h0077, 8'h03, 8'h05, 1'b1, OP_INSERT_NEW);
        vectors++; if (timed_out || rc_q[0] !== INSERT_NOT_SUCCESS_KEY_EXISTS || rh_q[0] !== 1) begin
            errors++; $display("FAIL new_exists: got code=%0d hops=%0d want %0d/1", rc_q[0], rh_q[0], INSERT_NOT_SUCCESS_KEY_EXISTS); end
        vectors++; if (wa_q.size() !== 0 || ack_n !== 0 || res_q[0] - acc_q[0] !== 4) begin
            errors++; $display("FAIL new_side: got wr=%0d ack=%0d lat=%0d want 0/0/4", wa_q.size(), ack_n, res_q[0] - acc_q[0]); end
        run_task(16'h0077, 16'h0001, 8'h03, 8'h05, 1'b1, OP_UPDATE);
        vectors++; if (timed_out || rc_q[0] !== UPDATE_NOT_SUCCESS_NO_KEY || rh_q[0] !== 2) begin
            errors++; $display("FAIL upd_absent: got code=%0d hops=%0d want %0d/2", rc_q[0], rh_q[0], UPDATE_NOT_SUCCESS_NO_KEY); end
        vectors++; if (wa_q.size() !== 0 || ack_n !== 0 || res_q[0] - acc_q[0] !== 7) begin
            errors++; $display("FAIL upd_absent_side: got wr=%0d ack=%0d lat=%0d want 0/0/7", wa_q.size(), ack_n, res_q[0] - acc_q[0]); end
        run_task(16'h0077, 16'h0001, 8'h04, 8'h00, 1'b0, OP_UPDATE);
        vectors++; if (timed_out || rc_q[0] !== UPDATE_NOT_SUCCESS_NO_KEY || ack_n !== 0 || hw_n !== 0) begin
            errors++; $display("FAIL upd_empty: got code=%0d ack=%0d hw=%0d want %0d/0/0", rc_q[0], ack_n, hw_n, UPDATE_NOT_SUCCESS_NO_KEY); end
        run_task(16'h0011, 16'h0099, 8'h03, 8'h05, 1'b1, OP_UPDATE);
        vectors++; if (timed_out || rc_q[0] !== UPDATE_SUCCESS || res_q[0] - acc_q[0] !== 5) begin
            errors++; $display("FAIL upd_hit: got code=%0d lat=%0d want %0d/5", rc_q[0], res_q[0] - acc_q[0], UPDATE_SUCCESS); end
        vectors++; if (wa_q.size() !== 1 || wa_q[0] !== 8'h05 || wd_q[0] !== mk(16'h11, 16'h99, 8'h09, 1'b1)) begin
            errors++; $display("FAIL upd_write: got n=%0d a=%h d=%h want a=05 d=%h", wa_q.size(), wa_q[0], wd_q[0], mk(16'h11, 16'h99, 8'h09, 1'b1)); end
    endtask

    task automatic test_chain_limit();
        run_task(16'h0044, 16'h0001, 8'h03, 8'h05, 1'b1, OP_INSERT);
        vectors++; if (timed_out || rc_q[0] !== INSERT_NOT_SUCCESS_CHAIN_LIMIT || rh_q[0] !== 2) begin
            errors++; $display("FAIL limit_code: got code=%0d hops=%0d want %0d/2", rc_q[0], rh_q[0], INSERT_NOT_SUCCESS_CHAIN_LIMIT); end
        vectors++; if (wa_q.size() !== 0 || ack_n !== 0) begin errors++; $display("FAIL limit_side: got wr=%0d ack=%0d want 0/0", wa_q.size(), ack_n); end
    endtask

    task automatic test_tail_append();
        poke(8'h20, mk(16'h33, 16'h30, 8'h00, 1'b0));
        empty_addr_val_i = 1'b0;
        run_task(16'h0055, 16'h005A, 8'h07, 8'h20, 1'b1, OP_INSERT);
        vectors++; if (timed_out || rc_q[0] !== INSERT_NOT_SUCCESS_TABLE_IS_FULL || rh_q[0] !== 1) begin
            errors++; $display("FAIL full_code: got code=%0d hops=%0d want %0d/1", rc_q[0], rh_q[0], INSERT_NOT_SUCCESS_TABLE_IS_FULL); end
        vectors++; if (wa_q.size() !== 0 || ack_n !== 0 || res_q[0] - acc_q[0] !== 4) begin
            errors++; $display("FAIL full_side: got wr=%0d ack=%0d lat=%0d want 0/0/4", wa_q.size(), ack_n, res_q[0] - acc_q[0]); end
        empty_addr_i = 8'h0C; empty_addr_val_i = 1'b1; result_ready_i = 1'b0;
        run_task(16'h0055, 16'h005A, 8'h07, 8'h20, 1'b1, OP_INSERT);
        vectors++; if (timed_out || rc_q[0] !== INSERT_SUCCESS || res_q[0] - acc_q[0] !== 6) begin
            errors++; $display("FAIL tail_code: got code=%0d lat=%0d want %0d/6", rc_q[0], res_q[0] - acc_q[0], INSERT_SUCCESS); end
        vectors++; if (wa_q.size() !== 2 || wa_q[0] !== 8'h0C || wd_q[0] !== mk(16'h55, 16'h5A, 8'h00, 1'b0)) begin
            errors++; $display("FAIL tail_new_node: got n=%0d a=%h d=%h want a=0C", wa_q.size(), wa_q[0], wd_q[0]); end
        vectors++; if (wa_q[1] !== 8'h20 || wd_q[1] !== mk(16'h33, 16'h30, 8'h0C, 1'b1) || wc_q[1] !== wc_q[0] + 1) begin
            errors++; $display("FAIL tail_link: got a=%h d=%h dc=%0d want a=20 d=%h dc=1", wa_q[1], wd_q[1], wc_q[1] - wc_q[0], mk(16'h33, 16'h30, 8'h0C, 1'b1)); end
        vectors++; if (ack_n !== 1) begin errors++; $display("FAIL tail_ack: got %0d want 1", ack_n); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++; if (result_valid_o !== 1'b1 || result_o.rslt !== INSERT_SUCCESS || result_o.key !== 16'h55 || result_hops_o !== 2'd1) begin
                errors++; $display("FAIL tail_hold%0d: got v=%b code=%0d key=%h hops=%0d want 1/%0d/0055/1", i, result_valid_o, result_o.rslt, result_o.key, result_hops_o, INSERT_SUCCESS); end
        end
        result_ready_i = 1'b1;
        @(posedge clk); #1;
        vectors++; if (result_valid_o !== 1'b0 || task_ready_o !== 1'b1) begin
            errors++; $display("FAIL tail_release: got v=%b rdy=%b want 0/1", result_valid_o, task_ready_o); end
    endtask

    task automatic test_back_to_back();
        int n;
        clear_logs();
        empty_addr_val_i = 1'b0;
        task_i = '{key: 16'h88, value: 16'h1, bucket: 8'h04, head_ptr: 8'h00, head_ptr_val: 1'b0, cmd: OP_UPDATE};
        task_valid_i = 1'b1;
        n = 0; while (acc_q.size() < 1 && n < 50) begin @(posedge clk); #1; n++; end
        task_i = '{key: 16'h11, value: 16'h1, bucket: 8'h03, head_ptr: 8'h05, head_ptr_val: 1'b1, cmd: OP_INSERT_NEW};
        n = 0; while (acc_q.size() < 2 && n < 50) begin @(posedge clk); #1; n++; end
        task_valid_i = 1'b0;
        n = 0; while (res_q.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
        vectors++; if (res_q.size() !== 2 || acc_q.size() !== 2 || acc_q[1] !== res_q[0] + 1) begin
            errors++; $display("FAIL b2b_accept: got res=%0d acc=%0d acc1-res0=%0d want 2/2/1", res_q.size(), acc_q.size(), acc_q[1] - res_q[0]); end
        vectors++; if (rc_q[0] !== UPDATE_NOT_SUCCESS_NO_KEY || rc_q[1] !== INSERT_NOT_SUCCESS_KEY_EXISTS) begin
            errors++; $display("FAIL b2b_codes: got %0d,%0d want %0d,%0d", rc_q[0], rc_q[1], UPDATE_NOT_SUCCESS_NO_KEY, INSERT_NOT_SUCCESS_KEY_EXISTS); end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_logs();
        task_i = '{key: 16'h99, value: 16'h1, bucket: 8'h03, head_ptr: 8'h05, head_ptr_val: 1'b1, cmd: OP_INSERT};
        task_valid_i = 1'b1;
        n = 0; while (acc_q.size() == 0 && n < 50) begin @(posedge clk); #1; n++; end
        task_valid_i = 1'b0;
        @(posedge clk); #2;
        rst_n_i = 1'b0;
        #1;
        vectors++; if ({rd_en_o, wr_en_o, empty_addr_rd_ack_o, ht.wr_en, result_valid_o, task_ready_o} !== 6'b000001) begin
            errors++; $display("FAIL rst_mid_strobes: got %b want 000001", {rd_en_o, wr_en_o, empty_addr_rd_ack_o, ht.wr_en, result_valid_o, task_ready_o}); end
        vectors++; if ({rd_addr_o, wr_addr_o, result_hops_o} !== '0) begin
            errors++; $display("FAIL rst_mid_data: got %h/%h/%h want 0", rd_addr_o, wr_addr_o, result_hops_o); end
        @(posedge clk); #1; rst_n_i = 1'b1;
        repeat (4) @(posedge clk); #1;
        vectors++; if (wa_q.size() !== 0 || res_q.size() !== 0) begin
            errors++; $display("FAIL rst_mid_abort: got wr=%0d res=%0d want 0/0", wa_q.size(), res_q.size()); end
        run_task(16'h0022, 16'h0077, 8'h03, 8'h05, 1'b1, OP_UPDATE);
        vectors++; if (timed_out || rc_q[0] !== UPDATE_SUCCESS || rh_q[0] !== 2 || res_q[0] - acc_q[0] !== 8) begin
            errors++; $display("FAIL rst_fresh: got code=%0d hops=%0d lat=%0d want %0d/2/8", rc_q[0], rh_q[0], res_q[0] - acc_q[0], UPDATE_SUCCESS); end
        vectors++; if (wa_q.size() !== 1 || wa_q[0] !== 8'h09 || wd_q[0] !== mk(16'h22, 16'h77, 8'h00, 1'b0)) begin
            errors++; $display("FAIL rst_fresh_write: got n=%0d a=%h d=%h want a=09", wa_q.size(), wa_q[0], wd_q[0]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_head_insert();
        test_same_key();
        test_insert_new_update();
        test_chain_limit();
        test_tail_append();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

`default_nettype wire
